// File: rtl/adc8_pkg.sv
// rtl/adc8_pkg.sv - FSM encoding and default timing constants for adc8_conv_ctrl
package adc8_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        WAIT_EOC = 2'd2
    } state_t;

    // 100 kHz sample rate from the 100 MHz system clock
    localparam int PERIOD_CYC_100K = 1000;
    localparam int CONVST_CYC_DEF  = 50;
    localparam int TIMEOUT_CYC_DEF = 400;

endpackage

// File: rtl/sync_fall_detect.sv
// rtl/sync_fall_detect.sv - 2-FF synchronizer with one-cycle falling-edge pulse
// Flops reset high so an idle-high input never produces a spurious edge.
module sync_fall_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic fall
);

    logic meta_q, sync_q, prev_q;
    logic meta_d, sync_d, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/adc8_conv_ctrl.sv
// rtl/adc8_conv_ctrl.sv - periodic CONVST generator and EOC-driven sample capture for one ADC
// Optional 4-sample moving average when ADC8_AVG_EN is defined.
module adc8_conv_ctrl
    import adc8_pkg::*;
#(
    parameter int N_BIT       = 8,
    parameter int PERIOD_CYC  = PERIOD_CYC_100K,
    parameter int CONVST_CYC  = CONVST_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_EN,
    input  logic             i_CLR,
    input  logic [N_BIT-1:0] i_ADC_DATA,
    input  logic             i_ADC_EOC,
    output logic             o_ADC_CONVST,
    output logic [N_BIT-1:0] o_DATA,
    output logic             o_VALID,
    output logic             o_BUSY,
    output logic             o_TIMEOUT,
    output logic             o_OVERRUN
);

    localparam int PW = $clog2(PERIOD_CYC);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYC - 1);
    localparam logic [TW-1:0] CV_LAST  = TW'(CONVST_CYC - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic [PW-1:0]    per_cnt_q, per_cnt_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             convst_q, convst_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic [N_BIT-1:0] data_q, data_d;
    logic             tick, eoc_fall, capture, to_set, ov_set;

    sync_fall_detect u_eoc_sync (
        .clk   (i_CLK),
        .rst_n (i_RST),
        .din   (i_ADC_EOC),
        .fall  (eoc_fall)
    );

    // tmr_q counts from the CONVST rise, so the timeout is measured from there too
    always_comb begin
        tick      = i_EN && (per_cnt_q == '0);
        per_cnt_d = '0;
        if (i_EN) begin
            per_cnt_d = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + 1'b1;
        end
        state_d  = state_q;
        tmr_d    = tmr_q;
        convst_d = convst_q;
        valid_d  = 1'b0;
        capture  = 1'b0;
        to_set   = 1'b0;
        ov_set   = tick && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d  = START;
                    convst_d = 1'b1;
                    tmr_d    = '0;
                end
            end
            START: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == CV_LAST) begin
                    state_d  = WAIT_EOC;
                    convst_d = 1'b0;
                end
            end
            WAIT_EOC: begin
                tmr_d = tmr_q + 1'b1;
                if (eoc_fall) begin
                    capture = 1'b1;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else if (tmr_q == TO_LAST) begin
                    to_set  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // disabling abandons the conversion silently
        if (!i_EN) begin
            state_d  = IDLE;
            convst_d = 1'b0;
            valid_d  = 1'b0;
            capture  = 1'b0;
            to_set   = 1'b0;
        end
        busy_d    = (state_d == START) || (state_d == WAIT_EOC);
        timeout_d = to_set | (timeout_q & ~i_CLR);
        overrun_d = ov_set | (overrun_q & ~i_CLR);
    end

`ifdef ADC8_AVG_EN
    logic [N_BIT-1:0] hist_q [4];
    logic [N_BIT-1:0] hist_d [4];
    logic [N_BIT+1:0] sum_q, sum_d;

    // running sum tracks the history exactly because both reset to zero
    always_comb begin
        hist_d = hist_q;
        sum_d  = sum_q;
        data_d = data_q;
        if (capture) begin
            hist_d[0] = i_ADC_DATA;
            for (int i = 1; i < 4; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            sum_d  = sum_q + (N_BIT+2)'(i_ADC_DATA) - (N_BIT+2)'(hist_q[3]);
            data_d = sum_d[N_BIT+1:2];
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            hist_q <= '{default: '0};
            sum_q  <= '0;
        end else begin
            hist_q <= hist_d;
            sum_q  <= sum_d;
        end
    end
`else
    always_comb begin
        data_d = data_q;
        if (capture) begin
            data_d = i_ADC_DATA;
        end
    end
`endif

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q   <= IDLE;
            per_cnt_q <= '0;
            tmr_q     <= '0;
            convst_q  <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            tmr_q     <= tmr_d;
            convst_q  <= convst_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            data_q    <= data_d;
        end
    end

    assign o_ADC_CONVST = convst_q;
    assign o_DATA       = data_q;
    assign o_VALID      = valid_q;
    assign o_BUSY       = busy_q;
    assign o_TIMEOUT    = timeout_q;
    assign o_OVERRUN    = overrun_q;

endmodule
